// File: rtl/frame_mon_pkg.sv
// -----------------------------------------------------------------------------
// frame_mon_pkg
// Shared types and constants for the frame difference monitor.
//   mon_state_t  : alarm FSM state encoding (OK, PEND, ALARM, CLR)
//   AVG_MIN_RST  : cleared value of the running minimum (largest 8-bit value)
//   AVG_MAX_RST  : cleared value of the running maximum (smallest 8-bit value)
//   RUN_W        : width of the alarm run counter
//   umin8/umax8  : unsigned 8-bit min/max helpers
// -----------------------------------------------------------------------------
package frame_mon_pkg;

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_PEND  = 2'd1,
      ST_ALARM = 2'd2,
      ST_CLR   = 2'd3
   } mon_state_t;

   localparam logic [7:0] AVG_MIN_RST = 8'hFF;
   localparam logic [7:0] AVG_MAX_RST = 8'h00;
   localparam int         RUN_W       = 4;

   function automatic logic [7:0] umin8(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [7:0] umax8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mon_alarm_fsm.sv
// -----------------------------------------------------------------------------
// mon_alarm_fsm
// Debounced alarm: trips after N_TRIP consecutive above-threshold frames and
// releases after N_CLEAR consecutive below-threshold frames. State only moves
// on frame events.
// Ports:
//   clk         in  : clock
//   rst         in  : synchronous active-high reset
//   frame_event in  : one-cycle frame event strobe
//   above       in  : frame difference is at or above the threshold
//   alarm       out : registered alarm level (ALARM or CLR)
//   alarm_rise  out : registered one-cycle pulse on entry to ALARM from OK/PEND
// -----------------------------------------------------------------------------
module mon_alarm_fsm
   import frame_mon_pkg::*;
#(
   parameter int N_TRIP  = 3,
   parameter int N_CLEAR = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_event,
   input  logic above,
   output logic alarm,
   output logic alarm_rise
);

   localparam logic [RUN_W-1:0] TRIP_N  = RUN_W'(N_TRIP);
   localparam logic [RUN_W-1:0] CLEAR_N = RUN_W'(N_CLEAR);

   mon_state_t       r_state;
   logic [RUN_W-1:0] r_run;
   logic             r_alarm;
   logic             r_alarm_rise;

   mon_state_t       w_state_nxt;
   logic [RUN_W-1:0] w_run_nxt;
   logic [RUN_W-1:0] w_run_inc;
   logic             w_alarm_nxt;
   logic             w_rise_nxt;

   assign w_run_inc = r_run + 4'd1;

   // State register, run counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_OK;
         r_run        <= 4'd0;
         r_alarm      <= 1'b0;
         r_alarm_rise <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_run        <= w_run_nxt;
         r_alarm      <= w_alarm_nxt;
         r_alarm_rise <= w_rise_nxt;
      end
   end

   // Next-state and run-counter logic, evaluated only on frame events
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (frame_event) begin
         case (r_state)
            ST_OK: begin
               if (above) begin
                  if (TRIP_N == 4'd1) begin
                     w_state_nxt = ST_ALARM;
                     w_run_nxt   = 4'd0;
                  end else begin
                     w_state_nxt = ST_PEND;
                     w_run_nxt   = 4'd1;
                  end
               end else begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = r_run;
               end
            end
            ST_PEND: begin
               if (above) begin
                  if (w_run_inc == TRIP_N) begin
                     w_state_nxt = ST_ALARM;
                     w_run_nxt   = 4'd0;
                  end else begin
                     w_state_nxt = ST_PEND;
                     w_run_nxt   = w_run_inc;
                  end
               end else begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = 4'd0;
               end
            end
            ST_ALARM: begin
               if (above) begin
                  w_state_nxt = ST_ALARM;
                  w_run_nxt   = r_run;
               end else if (CLEAR_N == 4'd1) begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = 4'd0;
               end else begin
                  w_state_nxt = ST_CLR;
                  w_run_nxt   = 4'd1;
               end
            end
            ST_CLR: begin
               if (above) begin
                  w_state_nxt = ST_ALARM;
                  w_run_nxt   = 4'd0;
               end else if (w_run_inc == CLEAR_N) begin
                  w_state_nxt = ST_OK;
                  w_run_nxt   = 4'd0;
               end else begin
                  w_state_nxt = ST_CLR;
                  w_run_nxt   = w_run_inc;
               end
            end
            default: begin
               w_state_nxt = ST_OK;
               w_run_nxt   = 4'd0;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
         w_run_nxt   = r_run;
      end
   end

   // Output decode from the next state so the outputs can be registered
   always_comb begin
      w_alarm_nxt = 1'b0;
      w_rise_nxt  = 1'b0;
      if ((w_state_nxt == ST_ALARM) || (w_state_nxt == ST_CLR)) begin
         w_alarm_nxt = 1'b1;
      end else begin
         w_alarm_nxt = 1'b0;
      end
      // CLR->ALARM re-entry is not a new alarm, so only OK/PEND origins pulse
      if (frame_event && (w_state_nxt == ST_ALARM) &&
          ((r_state == ST_OK) || (r_state == ST_PEND))) begin
         w_rise_nxt = 1'b1;
      end else begin
         w_rise_nxt = 1'b0;
      end
   end

   assign alarm      = r_alarm;
   assign alarm_rise = r_alarm_rise;

endmodule

// File: rtl/frame_diff_monitor.sv
// -----------------------------------------------------------------------------
// frame_diff_monitor
// Captures the averager result on every completed frame (rising edge of done)
// and keeps running statistics plus a debounced difference alarm.
// Ports:
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   done       in  : averager done level; its rising edge marks a frame
//   avg_in     in  : 8-bit frame average
//   diff_in    in  : 8-bit frame absolute difference
//   clr_stats  in  : synchronous clear of statistics only
//   stat_valid out : one-cycle pulse after statistics were updated
//   frame_cnt  out : saturating frame counter
//   avg_min    out : minimum average seen
//   avg_max    out : maximum average seen
//   diff_peak  out : maximum difference seen
//   alarm      out : alarm level
//   alarm_rise out : one-cycle pulse on alarm assertion
// -----------------------------------------------------------------------------
module frame_diff_monitor
   import frame_mon_pkg::*;
#(
   parameter logic [7:0] THRESH  = 8'd16,
   parameter int         N_TRIP  = 3,
   parameter int         N_CLEAR = 2,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done,
   input  logic [7:0]       avg_in,
   input  logic [7:0]       diff_in,
   input  logic             clr_stats,
   output logic             stat_valid,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [7:0]       avg_min,
   output logic [7:0]       avg_max,
   output logic [7:0]       diff_peak,
   output logic             alarm,
   output logic             alarm_rise
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             r_done_q;
   logic             r_stat_valid;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [7:0]       r_avg_min;
   logic [7:0]       r_avg_max;
   logic [7:0]       r_diff_peak;

   logic             w_event;
   logic             w_above;
   logic [CNT_W-1:0] w_cnt_base;
   logic [7:0]       w_min_base;
   logic [7:0]       w_max_base;
   logic [7:0]       w_peak_base;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       w_min_nxt;
   logic [7:0]       w_max_nxt;
   logic [7:0]       w_peak_nxt;

   // done_q resets high so a done level already present at reset is not a frame
   assign w_event = done & ~r_done_q;
   assign w_above = (diff_in >= THRESH);

   // Clear is applied first so a coincident event lands on the cleared values
   always_comb begin
      w_cnt_base  = r_frame_cnt;
      w_min_base  = r_avg_min;
      w_max_base  = r_avg_max;
      w_peak_base = r_diff_peak;
      if (clr_stats) begin
         w_cnt_base  = {CNT_W{1'b0}};
         w_min_base  = AVG_MIN_RST;
         w_max_base  = AVG_MAX_RST;
         w_peak_base = 8'h00;
      end else begin
         w_cnt_base  = r_frame_cnt;
         w_min_base  = r_avg_min;
         w_max_base  = r_avg_max;
         w_peak_base = r_diff_peak;
      end
   end

   // Fold the sampled frame into the statistics on an event
   always_comb begin
      w_cnt_nxt  = w_cnt_base;
      w_min_nxt  = w_min_base;
      w_max_nxt  = w_max_base;
      w_peak_nxt = w_peak_base;
      if (w_event) begin
         if (w_cnt_base == CNT_MAX) begin
            w_cnt_nxt = w_cnt_base;
         end else begin
            w_cnt_nxt = w_cnt_base + CNT_ONE;
         end
         w_min_nxt  = umin8(w_min_base, avg_in);
         w_max_nxt  = umax8(w_max_base, avg_in);
         w_peak_nxt = umax8(w_peak_base, diff_in);
      end else begin
         w_cnt_nxt  = w_cnt_base;
         w_min_nxt  = w_min_base;
         w_max_nxt  = w_max_base;
         w_peak_nxt = w_peak_base;
      end
   end

   // Edge-detect and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_q     <= 1'b1;
         r_stat_valid <= 1'b0;
         r_frame_cnt  <= {CNT_W{1'b0}};
         r_avg_min    <= AVG_MIN_RST;
         r_avg_max    <= AVG_MAX_RST;
         r_diff_peak  <= 8'h00;
      end else begin
         r_done_q     <= done;
         r_stat_valid <= w_event;
         r_frame_cnt  <= w_cnt_nxt;
         r_avg_min    <= w_min_nxt;
         r_avg_max    <= w_max_nxt;
         r_diff_peak  <= w_peak_nxt;
      end
   end

   mon_alarm_fsm #(
      .N_TRIP  (N_TRIP),
      .N_CLEAR (N_CLEAR)
   ) u_alarm_fsm (
      .clk         (clk),
      .rst         (rst),
      .frame_event (w_event),
      .above       (w_above),
      .alarm       (alarm),
      .alarm_rise  (alarm_rise)
   );

   assign stat_valid = r_stat_valid;
   assign frame_cnt  = r_frame_cnt;
   assign avg_min    = r_avg_min;
   assign avg_max    = r_avg_max;
   assign diff_peak  = r_diff_peak;

endmodule

// File: tb/tb_frame_diff_monitor.sv
// -----------------------------------------------------------------------------
// tb_frame_diff_monitor
// Directed bench for frame_diff_monitor with default parameters
// (THRESH=16, N_TRIP=3, N_CLEAR=2, CNT_W=16). Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_frame_diff_monitor;

   logic        clk;
   logic        rst;
   logic        done;
   logic [7:0]  avg_in;
   logic [7:0]  diff_in;
   logic        clr_stats;
   logic        stat_valid;
   logic [15:0] frame_cnt;
   logic [7:0]  avg_min;
   logic [7:0]  avg_max;
   logic [7:0]  diff_peak;
   logic        alarm;
   logic        alarm_rise;

   int n_tests;
   int n_fail;

   frame_diff_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .done       (done),
      .avg_in     (avg_in),
      .diff_in    (diff_in),
      .clr_stats  (clr_stats),
      .stat_valid (stat_valid),
      .frame_cnt  (frame_cnt),
      .avg_min    (avg_min),
      .avg_max    (avg_max),
      .diff_peak  (diff_peak),
      .alarm      (alarm),
      .alarm_rise (alarm_rise)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_stats(input string tag, input logic [15:0] e_cnt, input logic [7:0] e_min,
                            input logic [7:0] e_max, input logic [7:0] e_peak);
      chk({tag, "/cnt"},  32'(frame_cnt), 32'(e_cnt));
      chk({tag, "/min"},  32'(avg_min),   32'(e_min));
      chk({tag, "/max"},  32'(avg_max),   32'(e_max));
      chk({tag, "/peak"}, 32'(diff_peak), 32'(e_peak));
   endtask

   // One frame: done low for a cycle, then high with the sample (event cycle);
   // outputs are checked one cycle after the event, pulses again a cycle later.
   task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                        input logic clr, input logic e_alarm, input logic e_rise);
      @(negedge clk) done = 1'b0;
      @(negedge clk) begin
         done      = 1'b1;
         avg_in    = a;
         diff_in   = d;
         clr_stats = clr;
      end
      @(negedge clk) clr_stats = 1'b0;
      chk({tag, "/sv"},    32'(stat_valid), 32'd1);
      chk({tag, "/alarm"}, 32'(alarm),      32'(e_alarm));
      chk({tag, "/rise"},  32'(alarm_rise), 32'(e_rise));
      @(negedge clk);
      chk({tag, "/sv_off"},   32'(stat_valid), 32'd0);
      chk({tag, "/rise_off"}, 32'(alarm_rise), 32'd0);
      chk({tag, "/alarm_hold"}, 32'(alarm), 32'(e_alarm));
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      done      = 1'b1;
      avg_in    = 8'd0;
      diff_in   = 8'd0;
      clr_stats = 1'b0;

      // Reset with done high, then keep done high: no frame event
      repeat (3) @(negedge clk);
      chk_stats("rst", 16'd0, 8'hFF, 8'h00, 8'h00);
      chk("rst/alarm", 32'(alarm), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst/sv", 32'(stat_valid), 32'd0);
      end
      chk_stats("post_rst", 16'd0, 8'hFF, 8'h00, 8'h00);
      chk("post_rst/alarm", 32'(alarm), 32'd0);

      // First frame
      frame("f1", 8'd40, 8'd5, 1'b0, 1'b0, 1'b0);
      chk_stats("f1", 16'd1, 8'd40, 8'd40, 8'd5);

      // Three frames at threshold trip the alarm on the third
      frame("t1", 8'd50, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("t2", 8'd30, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("t3", 8'd60, 8'd16, 1'b0, 1'b1, 1'b1);
      chk_stats("trip", 16'd4, 8'd30, 8'd60, 8'd16);

      // One below (CLR), then above returns to ALARM without a new rise
      frame("c1", 8'd45, 8'd15, 1'b0, 1'b1, 1'b0);
      frame("c2", 8'd45, 8'd20, 1'b0, 1'b1, 1'b0);

      // Two below-frames release the alarm
      frame("r1", 8'd45, 8'd3, 1'b0, 1'b1, 1'b0);
      frame("r2", 8'd45, 8'd3, 1'b0, 1'b0, 1'b0);
      chk_stats("release", 16'd8, 8'd30, 8'd60, 8'd20);

      // Interrupted run never trips
      frame("i1", 8'd45, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("i2", 8'd45, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("i3", 8'd45, 8'd2,  1'b0, 1'b0, 1'b0);
      frame("i4", 8'd45, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("i5", 8'd45, 8'd16, 1'b0, 1'b0, 1'b0);

      // done held high three cycles counts once (frame leaves done high)
      frame("hold", 8'd45, 8'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold/sv3", 32'(stat_valid), 32'd0);
      chk("hold/cnt", 32'(frame_cnt), 32'd14);

      // clr_stats alone clears the statistics without a stat_valid pulse
      clr_stats = 1'b1;
      @(negedge clk) clr_stats = 1'b0;
      chk("clr/sv", 32'(stat_valid), 32'd0);
      chk_stats("clr", 16'd0, 8'hFF, 8'h00, 8'h00);

      // clr_stats coincident with an event
      frame("f2", 8'd90, 8'd30, 1'b0, 1'b0, 1'b0);
      chk_stats("f2", 16'd1, 8'd90, 8'd90, 8'd30);
      frame("clrev", 8'd7, 8'd9, 1'b1, 1'b0, 1'b0);
      chk_stats("clrev", 16'd1, 8'd7, 8'd7, 8'd9);

      // Reset while in PEND: the run restarts from zero
      frame("p1", 8'd7, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("p2", 8'd7, 8'd16, 1'b0, 1'b0, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("prst/alarm", 32'(alarm), 32'd0);
      chk("prst/rise",  32'(alarm_rise), 32'd0);
      chk_stats("prst", 16'd0, 8'hFF, 8'h00, 8'h00);
      frame("q1", 8'd7, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("q2", 8'd7, 8'd16, 1'b0, 1'b0, 1'b0);
      frame("q3", 8'd7, 8'd16, 1'b0, 1'b1, 1'b1);
      chk_stats("q3", 16'd3, 8'd7, 8'd7, 8'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
